// File: rtl/seq_serializer.sv
// Parallel-in, serial-out shifter feeding the sequence detector; optional even parity bit via SER_PARITY_EN.
// Latency: bit k of a word appears on ser_out k+1 cycles after the accept edge (WIDTH or WIDTH+1 cycles per word).
// Backpressure: in_ready high only in IDLE or the final serial cycle of a word, so back-to-back words are gapless.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Ready is a pure decode of state so the upstream sees it before the edge.
    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
`ifdef SER_PARITY_EN
                SHIFT:   in_ready = 1'b0;
                PARITY:  in_ready = 1'b1;
`else
                SHIFT:   in_ready = (cnt_q == '0);
`endif
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = in_data;
                    cnt_d   = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            SHIFT: begin
                shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    if (accept) begin
                        shreg_d = in_data;
                        cnt_d   = CW'(WIDTH - 1);
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = in_data;
                    cnt_d   = CW'(WIDTH - 1);
                    par_d   = ^in_data;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Serial outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            SHIFT: begin
                ser_out_d   = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                ser_out_d   = par_d;
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
`endif
            default: begin
                ser_out_d   = IDLE_BIT;
                ser_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: MSB-first and LSB-first instances, WIDTH=8, parity-aware when SER_PARITY_EN is set.
// Latency: checks bit k on ser_out k+1 cycles after accept, WIDTH (or WIDTH+1) cycles per word.
// Backpressure: checks in_ready only in final serial cycle, held in_valid accepted exactly once.
module tb_seq_serializer;

`ifdef SER_PARITY_EN
    localparam int L = 9;
`else
    localparam int L = 8;
`endif

    localparam time TIMEOUT = 100000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, ser_out, ser_valid, busy;
    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ready, l_ser_out, l_ser_valid, l_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (l_data),
        .in_valid  (l_valid),
        .in_ready  (l_ready),
        .ser_out   (l_ser_out),
        .ser_valid (l_ser_valid),
        .busy      (l_busy)
    );

    // Expected bit j of a word in send order; j==8 is the even parity bit.
    function automatic logic exp_bit(input logic [7:0] w, input int j, input bit msb);
        if (j >= 8) return ^w;
        return msb ? w[7-j] : w[j];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #TIMEOUT;
        errors++;
        $error("FAIL timeout: stimulus did not complete within %0t", TIMEOUT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] w;
        int         j;

        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        l_data   = 8'h00;
        l_valid  = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ser_out", ser_out, 1'b1);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lsb_ser_out", l_ser_out, 1'b1);

        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // Single word 0x24 MSB first
        in_data  = 8'h24;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < L; k++) begin
            chk("w24_valid", ser_valid, 1'b1);
            chk("w24_busy", busy, 1'b1);
            chk("w24_bit", ser_out, exp_bit(8'h24, k, 1'b1));
            chk("w24_ready", in_ready, (k == L - 1));
            tick();
        end
        chk("w24_idle_out", ser_out, 1'b1);
        chk("w24_idle_valid", ser_valid, 1'b0);
        chk("w24_idle_busy", busy, 1'b0);

        // Back-to-back A5 then 3C with in_valid held
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        for (int k = 0; k < 2 * L; k++) begin
            w = (k < L) ? 8'hA5 : 8'h3C;
            j = k % L;
            chk("b2b_valid", ser_valid, 1'b1);
            chk("b2b_bit", ser_out, exp_bit(w, j, 1'b1));
            chk("b2b_ready", in_ready, (j == L - 1));
            if (k == L) in_valid = 1'b0;
            tick();
        end
        chk("b2b_idle_valid", ser_valid, 1'b0);

        // Held valid while busy: in_data churns until just before the ready edge
        in_data  = 8'h0F;
        in_valid = 1'b1;
        tick();
        in_data = 8'h55;
        for (int k = 0; k < 2 * L; k++) begin
            w = (k < L) ? 8'h0F : 8'h55;
            j = k % L;
            chk("hold_valid", ser_valid, 1'b1);
            chk("hold_bit", ser_out, exp_bit(w, j, 1'b1));
            if (k < L - 2) in_data = 8'($urandom);
            else if (k < L) in_data = 8'h55;
            if (k == L) in_valid = 1'b0;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk("hold_once_valid", ser_valid, 1'b0);
            chk("hold_once_out", ser_out, 1'b1);
            tick();
        end

        // Back-to-back 07 then 03 (parity 1 then 0 when parity is on)
        in_data  = 8'h07;
        in_valid = 1'b1;
        tick();
        in_data = 8'h03;
        for (int k = 0; k < 2 * L; k++) begin
            w = (k < L) ? 8'h07 : 8'h03;
            j = k % L;
            chk("par_valid", ser_valid, 1'b1);
            chk("par_bit", ser_out, exp_bit(w, j, 1'b1));
            chk("par_ready", in_ready, (j == L - 1));
            if (k == L) in_valid = 1'b0;
            tick();
        end
        chk("par_idle_valid", ser_valid, 1'b0);

        // Reset during the 4th bit of 0xFF
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rmid_bit", ser_out, 1'b1);
            tick();
        end
        chk("rmid_4th_valid", ser_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("rmid_out", ser_out, 1'b1);
        chk("rmid_valid", ser_valid, 1'b0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_ready", in_ready, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        chk("rmid_rel_ready", in_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk("rmid_no_tail", ser_valid, 1'b0);
            tick();
        end

        // LSB-first instance, word 0x01
        l_data  = 8'h01;
        l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int k = 0; k < L; k++) begin
            chk("lsb_valid", l_ser_valid, 1'b1);
            chk("lsb_bit", l_ser_out, exp_bit(8'h01, k, 1'b0));
            tick();
        end
        chk("lsb_idle_valid", l_ser_valid, 1'b0);
        chk("lsb_idle_out", l_ser_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-in, serial-out shifter that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which drives the detector's inp. While idle it drives a programmable fill bit, so idle periods do not advance the detector toward a match.

Parameters:
WIDTH, 8, data word width in bits; legal range is 2 or more.
MSB_FIRST, 1, set to 1 to send bit WIDTH-1 first; set to 0 to send bit 0 first.
IDLE_BIT, 1, level driven on ser_out whenever no bit is being sent.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_data  input  WIDTH  parallel word to serialise.
in_valid  input  1  in_data is valid.
in_ready  output  1  serialiser can take a word this cycle.
ser_out  output  1  serial bit stream; connects to the detector's inp.
ser_valid  output  1  ser_out carries a data or parity bit this cycle.
busy  output  1  a word is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=IDLE_BIT, ser_valid=0, busy=0.
  - in_ready is forced to 0 while reset is low.
- Reset mid-word: the in-flight word is discarded and no partial bits follow.
- First cycle after reset release: in_ready=1.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature).
- Accept rule: a word is accepted on a rising edge where in_valid=1 and in_ready=1. in_data is copied into the shift register and the counter is loaded with WIDTH-1.
- in_ready is combinational from state:
  - 1 in IDLE.
  - 1 in the final serial cycle of a word: last data bit, or the parity bit when the optional feature is on.
  - 0 otherwise.
- IDLE:
  - ser_out=IDLE_BIT, ser_valid=0, busy=0.
  - On accept, go to SHIFT.
- SHIFT:
  - ser_valid=1, busy=1.
  - ser_out = shift-register MSB when MSB_FIRST=1, else the LSB.
  - Each edge shifts one position and decrements the counter.
  - On the edge where counter=0:
    - Parity off: if an accept occurs, reload and stay in SHIFT (gapless back-to-back); otherwise go to IDLE.
    - Parity on: go to PARITY.
- Latency: the first bit of a word appears on ser_out in the cycle after the accept edge.
  - Bit k (k=0..WIDTH-1 in send order) appears k+1 cycles after the accept edge.
  - The word occupies exactly WIDTH cycles (WIDTH+1 with parity).
- Holding: in_data/in_valid may change freely while in_ready=0. A held in_valid is accepted exactly once, at the first in_ready=1 edge.
- Outputs ser_out, ser_valid and busy are registered (Moore-style); only in_ready is combinational.
- The counter is $clog2(WIDTH) bits wide and never wraps past 0.

Optional Feature:
Macro SER_PARITY_EN.
- When defined:
  - After the last data bit, one extra cycle in state PARITY drives ser_out = XOR of all WIDTH bits of the word (even parity), with ser_valid=1 and busy=1.
  - in_ready=1 only in that PARITY cycle, not in the last data cycle.
  - An accept there goes to SHIFT with no gap; otherwise the block goes to IDLE.
- When undefined:
  - The PARITY state and its logic are absent.
  - Each word is exactly WIDTH serial cycles.

Test Plan:
- WIDTH=8, MSB_FIRST=1; after reset release, accept 8'b0010_0100 -> ser_out = 0,0,1,0,0,1,0,0 on cycles 1..8 with ser_valid=1; cycle 9 ser_out=1, ser_valid=0. A detector connected downstream flags det twice.
- Back-to-back: in_valid held high with 8'hA5 then 8'h3C -> in_ready=1 during the 8th bit of 8'hA5; 16 consecutive ser_valid=1 cycles with no idle gap; in_ready=0 during bits 1..7 of each word.
- MSB_FIRST=0, accept 8'h01 -> ser_out = 1,0,0,0,0,0,0,0.
- Assert reset at the 4th bit of 8'hFF -> ser_out=1 (IDLE_BIT), ser_valid=0, busy=0 immediately; in_ready=1 the first cycle after release; no remaining bits emitted.
- Hold in_valid=1 with 8'h55 while busy -> in_data is not sampled until in_ready=1; changing in_data during that time has no effect on the word being sent; the word is sent exactly once.
- SER_PARITY_EN defined, accept 8'h07 -> 8 data bits, then parity bit 1 in cycle 9 with ser_valid=1; 8'h03 gives parity bit 0; in_ready=1 only in cycle 9.
